kbd_matrix_ctl: RTL and testbench



---
 rtl/kbd_matrix_ctl.sv | 156 +++++++++++++++
 tb/tb_kbd_matrix_ctl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_matrix_ctl.sv
// PS/2 scancode sequencer for the Vector-06C 8x8 key matrix.
// Parses prefixes, drives the scancode converter and maintains the matrix and modifier keys.
module kbd_matrix_ctl #(
    parameter int LOOKUP_LAT = 1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_ps2_data,
    input  logic       i_ps2_dsr,
    input  logic       i_kbd_flush,
    output logic [7:0] o_lk_scancode,
    input  logic [2:0] i_lk_row,
    input  logic [2:0] i_lk_col,
    input  logic       i_lk_error,
    input  logic [7:0] i_row_sel,
    output logic [7:0] o_keys_out,
    output logic       o_key_ss,
    output logic       o_key_us,
    output logic       o_key_rus,
    output logic       o_key_blksbr,
    output logic       o_busy,
    output logic       o_overflow
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_APPLY  = 2'd2;
    localparam int CW = $clog2(LOOKUP_LAT + 2);

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [7:0][7:0] r_matrix;
    logic [7:0]      r_scancode;
    logic [7:0]      r_buf;
    logic            r_buf_vld;
    logic            r_rel, r_ext, r_op_rel;
    logic [2:0]      r_skip;
    logic            r_ss, r_us, r_rus, r_blksbr, r_overflow;

    logic            w_idle, w_have;
    logic [7:0]      w_byte;
    logic [7:0]      w_keys;

    // The buffered byte always goes first so arrival order is preserved.
    assign w_idle = (r_state == S_IDLE);
    assign w_have = w_idle && (r_buf_vld || i_ps2_dsr);
    assign w_byte = r_buf_vld ? r_buf : i_ps2_data;

    always_comb begin
        w_keys = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r_matrix[r][c] && !i_row_sel[r]) w_keys[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_kbd_flush) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_matrix   <= '0;
            r_buf_vld  <= 1'b0;
            r_rel      <= 1'b0;
            r_ext      <= 1'b0;
            r_skip     <= 3'd0;
            r_ss       <= 1'b0;
            r_us       <= 1'b0;
            r_rus      <= 1'b0;
            r_blksbr   <= 1'b0;
            r_overflow <= 1'b0;
            if (!i_reset_n) begin
                r_scancode <= 8'h00;
                r_buf      <= 8'h00;
                r_op_rel   <= 1'b0;
            end
        end else begin
            r_overflow <= i_ps2_dsr && !w_idle && r_buf_vld;
            if (w_idle) begin
                if (r_buf_vld) begin
                    r_buf_vld <= i_ps2_dsr;
                    if (i_ps2_dsr) r_buf <= i_ps2_data;
                end
            end else if (i_ps2_dsr && !r_buf_vld) begin
                r_buf_vld <= 1'b1;
                r_buf     <= i_ps2_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_have) begin
                        if (r_skip != 3'd0) begin
                            r_skip <= r_skip - 3'd1;
                        end else begin
                            case (w_byte)
                                8'hE1: r_skip <= 3'd7;
                                8'hF0: r_rel  <= 1'b1;
                                8'hE0: r_ext  <= 1'b1;
                                8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: begin
                                    r_rel <= 1'b0;
                                    r_ext <= 1'b0;
                                end
                                // With E0 these are synthetic shifts around nav keys.
                                8'h12, 8'h59: begin
                                    if (!r_ext) r_ss <= !r_rel;
                                    r_rel <= 1'b0;
                                    r_ext <= 1'b0;
                                end
                                8'h14: begin
                                    r_us  <= !r_rel;
                                    r_rel <= 1'b0;
                                    r_ext <= 1'b0;
                                end
                                8'h58: begin
                                    r_rus <= !r_rel;
                                    r_rel <= 1'b0;
                                    r_ext <= 1'b0;
                                end
                                8'h07: begin
                                    r_blksbr <= !r_rel;
                                    r_rel    <= 1'b0;
                                    r_ext    <= 1'b0;
                                end
                                default: begin
                                    r_scancode <= w_byte;
                                    r_op_rel   <= r_rel;
                                    r_rel      <= 1'b0;
                                    r_ext      <= 1'b0;
                                    r_cnt      <= '0;
                                    r_state    <= S_LOOKUP;
                                end
                            endcase
                        end
                    end
                end
                S_LOOKUP: begin
                    if (r_cnt == CW'(LOOKUP_LAT)) r_state <= S_APPLY;
                    else                          r_cnt   <= r_cnt + 1'b1;
                end
                S_APPLY: begin
                    if (!i_lk_error) r_matrix[i_lk_row][i_lk_col] <= !r_op_rel;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_lk_scancode = r_scancode;
    assign o_keys_out    = w_keys;
    assign o_key_ss      = r_ss;
    assign o_key_us      = r_us;
    assign o_key_rus     = r_rus;
    assign o_key_blksbr  = r_blksbr;
    assign o_busy        = !w_idle;
    assign o_overflow    = r_overflow;
endmodule

// File: tb/tb_kbd_matrix_ctl.sv
// Directed bench for kbd_matrix_ctl with a registered converter model and a scancode scoreboard.
module tb_kbd_matrix_ctl;
    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_dsr = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] lk_scancode;
    logic [2:0] lk_row = 3'd0, lk_col = 3'd0;
    logic       lk_error = 1'b0;
    logic [7:0] row_sel = 8'hFF;
    logic [7:0] keys_out;
    logic       key_ss, key_us, key_rus, key_blksbr, busy, ovf;

    int n_cmp = 0;
    int n_err = 0;
    int ov_cnt = 0;
    logic [7:0][7:0] mdl = '0;
    logic [7:0] sc_q[$];
    logic       prev_busy = 1'b0;

    kbd_matrix_ctl #(.LOOKUP_LAT(LAT)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_ps2_data(ps2_data), .i_ps2_dsr(ps2_dsr),
        .i_kbd_flush(flush), .o_lk_scancode(lk_scancode), .i_lk_row(lk_row),
        .i_lk_col(lk_col), .i_lk_error(lk_error), .i_row_sel(row_sel),
        .o_keys_out(keys_out), .o_key_ss(key_ss), .o_key_us(key_us), .o_key_rus(key_rus),
        .o_key_blksbr(key_blksbr), .o_busy(busy), .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    // Registered converter: one clock from scancode to result.
    always @(posedge clk) begin
        lk_error <= 1'b0;
        lk_row   <= 3'd0;
        lk_col   <= 3'd0;
        case (lk_scancode)
            8'h1C: begin lk_row <= 3'd4; lk_col <= 3'd1; end
            8'h1B: begin lk_row <= 3'd2; lk_col <= 3'd3; end
            8'h23: begin lk_row <= 3'd7; lk_col <= 3'd7; end
            8'h2B: begin lk_row <= 3'd0; lk_col <= 3'd0; end
            default: lk_error <= 1'b1;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_keys(input logic [7:0] rs);
        logic [7:0] k;
        k = 8'hFF;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (mdl[r][c] && !rs[r]) k[c] = 1'b0;
        return k;
    endfunction

    // Scoreboard: every entry into LOOKUP must present the next expected scancode.
    always @(negedge clk) begin
        if (busy === 1'b1 && !prev_busy) begin
            if (sc_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL scq_underflow: observed %h expected none", lk_scancode);
            end else begin
                chk("lk_scancode_sb", lk_scancode, sc_q.pop_front());
            end
        end
        if (ovf === 1'b1) ov_cnt++;
        prev_busy = (busy === 1'b1);
    end

    task automatic send(input logic [7:0] b, input bit lk);
        if (lk) sc_q.push_back(b);
        ps2_data = b;
        ps2_dsr  = 1'b1;
        @(posedge clk); #1;
        ps2_dsr  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {7'd0, busy}, 8'h00);
    endtask

    task automatic chk_rows(input string tag);
        for (int r = 0; r < 8; r++) begin
            row_sel = ~(8'h01 << r);
            #1;
            chk(tag, keys_out, model_keys(row_sel));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        row_sel = 8'hFE;
        #1;
        chk("rst_keys", keys_out, 8'hFF);
        chk("rst_ss", {7'd0, key_ss}, 8'h00);
        chk("rst_us", {7'd0, key_us}, 8'h00);
        chk("rst_rus", {7'd0, key_rus}, 8'h00);
        chk("rst_blk", {7'd0, key_blksbr}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_ovf", {7'd0, ovf}, 8'h00);
        chk("rst_scancode", lk_scancode, 8'h00);

        // Make 1C with exact latency check
        send(8'h1C, 1'b1);
        chk("lookup_busy", {7'd0, busy}, 8'h01);
        chk("lookup_sc", lk_scancode, 8'h1C);
        row_sel = 8'hEF;
        repeat (LAT + 1) @(posedge clk);
        #1;
        chk("apply_busy", {7'd0, busy}, 8'h01);
        chk("apply_prewrite", keys_out, 8'hFF);
        @(posedge clk); #1;
        chk("post_busy", {7'd0, busy}, 8'h00);
        mdl[4][1] = 1'b1;
        chk("make_1c", keys_out, 8'hFD);

        send(8'hF0, 1'b0);
        send(8'h1C, 1'b1);
        wait_idle("idle_brk1c");
        mdl[4][1] = 1'b0;
        row_sel = 8'hEF;
        #1;
        chk("break_1c", keys_out, 8'hFF);

        // Modifiers
        send(8'h12, 1'b0);
        chk("ss_make", {7'd0, key_ss}, 8'h01);
        send(8'hE0, 1'b0); send(8'h12, 1'b0);
        chk("ss_fake", {7'd0, key_ss}, 8'h01);
        send(8'hF0, 1'b0); send(8'h12, 1'b0);
        chk("ss_break", {7'd0, key_ss}, 8'h00);
        send(8'hE0, 1'b0); send(8'h14, 1'b0);
        chk("us_ext", {7'd0, key_us}, 8'h01);
        send(8'h58, 1'b0);
        chk("rus_make", {7'd0, key_rus}, 8'h01);
        send(8'hF0, 1'b0); send(8'h58, 1'b0);
        chk("rus_break", {7'd0, key_rus}, 8'h00);
        send(8'h07, 1'b0);
        chk("blk_make", {7'd0, key_blksbr}, 8'h01);
        chk("mod_nobusy", {7'd0, busy}, 8'h00);

        // Pause sequence skipped
        send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0); send(8'hE1, 1'b0);
        send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0); send(8'h77, 1'b0);
        chk("e1_us", {7'd0, key_us}, 8'h01);
        chk("e1_ss", {7'd0, key_ss}, 8'h00);
        chk("e1_busy", {7'd0, busy}, 8'h00);
        send(8'h1C, 1'b1);
        wait_idle("idle_e1");
        mdl[4][1] = 1'b1;
        chk_rows("after_e1");

        // Three strobes back to back: buffer one, drop one
        sc_q.push_back(8'h1B);
        sc_q.push_back(8'h23);
        ps2_data = 8'h1B; ps2_dsr = 1'b1;
        @(posedge clk); #1;
        ps2_data = 8'h23;
        @(posedge clk); #1;
        ps2_data = 8'h2B;
        @(posedge clk); #1;
        ps2_dsr = 1'b0;
        chk("ovf_pulse", {7'd0, ovf}, 8'h01);
        @(posedge clk); #1;
        chk("ovf_end", {7'd0, ovf}, 8'h00);
        @(posedge clk); #1;
        chk("buf_lookup", {7'd0, busy}, 8'h01);
        wait_idle("idle_ovf");
        mdl[2][3] = 1'b1;
        mdl[7][7] = 1'b1;
        chk_rows("after_ovf");
        chk("ovf_count", 8'(ov_cnt), 8'h01);

        // Unmapped code
        send(8'h76, 1'b1);
        wait_idle("idle_unmapped");
        chk_rows("unmapped");

        // Flush during LOOKUP with three keys down
        send(8'h2B, 1'b1);
        chk("flush_pre_busy", {7'd0, busy}, 8'h01);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {7'd0, busy}, 8'h00);
        mdl = '0;
        row_sel = 8'h00;
        #1;
        chk("flush_keys", keys_out, 8'hFF);
        chk("flush_us", {7'd0, key_us}, 8'h00);
        chk("flush_blk", {7'd0, key_blksbr}, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        chk("flush_nolate", keys_out, 8'hFF);
        chk_rows("flush_rows");
        chk("scq_drained", 8'(sc_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
